// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter.
// ALU results write directly and have priority. Multdiv results are queued in a
// small FIFO and drain on cycles the ALU does not use the port. A starvation
// guard drops alu_ready for one cycle so that the FIFO cannot be locked out.
// Lookups on chk_regA/chk_regB report registers with a write still in flight,
// so issue logic can stall on RAW hazards.
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic [4:0]  chk_regA,
  input  logic [4:0]  chk_regB,
  output logic        chk_pendingA,
  output logic        chk_pendingB,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_rd_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;
  logic          r_we;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_alu_ready;
  logic          w_md_ready;
  logic          w_fifo_ne;
  logic          w_alu_fire;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic          w_pend_a;
  logic          w_pend_b;

  // An entry is live when its distance from the read pointer is below the count.
  function automatic logic entry_live(input logic [AW-1:0] idx,
                                      input logic [AW-1:0] rptr,
                                      input logic [CW-1:0] cnt);
    logic [AW-1:0] off;
    off = idx - rptr;
    return ({1'b0, off} < cnt);
  endfunction

  // Handshakes and arbitration, all from registered state so readies are glitch-free.
  always_comb begin
    w_alu_ready = (r_starve_cnt != SW'(STARVE_LIMIT));
    w_md_ready  = (r_count != CW'(DEPTH));
    w_fifo_ne   = (r_count != CW'(0));
    w_alu_fire  = alu_valid & w_alu_ready & (alu_rd != 5'd0);
    w_pop       = ~w_alu_fire & w_fifo_ne;
    w_push      = md_valid & w_md_ready & (md_rd != 5'd0);
  end

  // Next FIFO occupancy and starvation count.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_starve_nxt = r_starve_cnt;
    if (w_pop || !w_fifo_ne) begin
      w_starve_nxt = SW'(0);
    end else if (w_alu_fire) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // Pending-write lookup over live FIFO entries plus the write currently on the port.
  always_comb begin
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_a = w_pend_a | (entry_live(AW'(i), r_rptr, r_count) & (r_rd_mem[AW'(i)] == chk_regA));
      w_pend_b = w_pend_b | (entry_live(AW'(i), r_rptr, r_count) & (r_rd_mem[AW'(i)] == chk_regB));
    end
    w_pend_a = (w_pend_a | (r_we & (r_wreg == chk_regA))) & (chk_regA != 5'd0);
    w_pend_b = (w_pend_b | (r_we & (r_wreg == chk_regB))) & (chk_regB != 5'd0);
  end

  // FIFO storage; contents need no reset because liveness comes from the count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= md_rd;
      r_data_mem[r_wptr] <= md_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count      <= w_count_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Registered write port: ALU first, else FIFO head, else idle holding address/data.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_we    <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_alu_fire) begin
      r_we    <= 1'b1;
      r_wreg  <= alu_rd;
      r_wdata <= alu_data;
    end else if (w_pop) begin
      r_we    <= (r_rd_mem[r_rptr] != 5'd0);
      r_wreg  <= r_rd_mem[r_rptr];
      r_wdata <= r_data_mem[r_rptr];
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign alu_ready        = w_alu_ready;
  assign md_ready         = w_md_ready;
  assign chk_pendingA     = w_pend_a;
  assign chk_pendingB     = w_pend_b;
  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: stimulus pushes expected
// register-file writes, a negedge monitor pops and compares every write.
module tb_regfile_writeback_arbiter;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        ctrl_reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  chk_regA;
  logic [4:0]  chk_regB;
  logic        chk_pendingA;
  logic        chk_pendingB;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  wr_t exp_q[$];
  int  n_checks;
  int  n_fail;

  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .chk_regA(chk_regA), .chk_regB(chk_regB),
    .chk_pendingA(chk_pendingA), .chk_pendingB(chk_pendingB),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every write on the port must match the head of the scoreboard.
  always @(negedge clock) begin
    wr_t e;
    if (!ctrl_reset && ctrl_writeEnable) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg=%0d data=%h expected no write",
                 ctrl_writeReg, data_writeReg);
      end else begin
        e = exp_q.pop_front();
        if (ctrl_writeReg !== e.rd || data_writeReg !== e.data) begin
          n_fail++;
          $display("FAIL write_order: got reg=%0d data=%h expected reg=%0d data=%h",
                   ctrl_writeReg, data_writeReg, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    ctrl_reset = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_valid = 1'b0;  md_rd = 5'd0;  md_data = 32'd0;
    chk_regA = 5'd5;  chk_regB = 5'd0;

    // Reset state
    #1 ctrl_reset = 1'b1;
    #2;
    check("rst_we", 32'(ctrl_writeEnable), 32'd0);
    check("rst_reg", 32'(ctrl_writeReg), 32'd0);
    check("rst_data", data_writeReg, 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_md_ready", 32'(md_ready), 32'd1);
    check("rst_pendA", 32'(chk_pendingA), 32'd0);
    tick();
    tick();
    ctrl_reset = 1'b0;

    // Idle: no write for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_we", 32'(ctrl_writeEnable), 32'd0);
    end

    // ALU only: rd=5 writes one cycle later; rd=0 is discarded
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    check("alu_we", 32'(ctrl_writeEnable), 32'd1);
    check("alu_reg", 32'(ctrl_writeReg), 32'd5);
    alu_rd = 5'd0; alu_data = 32'h12345678;
    tick();
    check("alu_r0_we", 32'(ctrl_writeEnable), 32'd0);
    check("alu_r0_hold_reg", 32'(ctrl_writeReg), 32'd5);
    check("alu_r0_hold_data", data_writeReg, 32'hDEADBEEF);
    alu_valid = 1'b0;
    tick();

    // Fill FIFO while the ALU wins every cycle
    for (int i = 0; i < 4; i++) begin
      md_valid = 1'b1; md_rd = 5'(i + 1); md_data = 32'h10 + 32'(i);
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA0 + 32'(i);
      expect_wr(5'(10 + i), 32'hA0 + 32'(i));
      tick();
    end
    check("full_md_ready", 32'(md_ready), 32'd0);
    check("starve_alu_ready", 32'(alu_ready), 32'd0);
    check("full_count", 32'(dut.r_count), 32'd4);
    // Starved ALU held off; md push refused while full even though a pop occurs
    alu_rd = 5'd14; alu_data = 32'hA4;
    md_rd = 5'd9; md_data = 32'h99;
    expect_wr(5'd1, 32'h10);
    tick();
    check("pop_md_ready", 32'(md_ready), 32'd1);
    check("pop_alu_ready", 32'(alu_ready), 32'd1);
    check("pop_count", 32'(dut.r_count), 32'd3);
    alu_valid = 1'b0; md_valid = 1'b0;
    expect_wr(5'd2, 32'h11);
    tick();
    check("count2", 32'(dut.r_count), 32'd2);
    // Push and pop together at count 2
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h16;
    expect_wr(5'd3, 32'h12);
    tick();
    check("pushpop_count", 32'(dut.r_count), 32'd2);
    md_valid = 1'b0;
    expect_wr(5'd4, 32'h13);
    expect_wr(5'd6, 32'h16);
    tick();
    tick();
    check("drained_count", 32'(dut.r_count), 32'd0);
    tick();

    // Pending lookup for an md write to r7; port B on r0
    chk_regA = 5'd7; chk_regB = 5'd0;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
    tick();
    md_valid = 1'b0;
    check("pend_fifo_A", 32'(chk_pendingA), 32'd1);
    check("pend_r0_B", 32'(chk_pendingB), 32'd0);
    expect_wr(5'd7, 32'h77);
    tick();
    check("pend_write_we", 32'(ctrl_writeEnable), 32'd1);
    check("pend_write_A", 32'(chk_pendingA), 32'd1);
    tick();
    check("pend_after_A", 32'(chk_pendingA), 32'd0);
    // Pending from an ALU write on the port
    chk_regB = 5'd8;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    expect_wr(5'd8, 32'h88);
    tick();
    alu_valid = 1'b0;
    check("pend_alu_B", 32'(chk_pendingB), 32'd1);
    tick();
    check("pend_alu_B_clr", 32'(chk_pendingB), 32'd0);
    // md push to r0 is discarded
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
    tick();
    md_valid = 1'b0;
    check("md_r0_count", 32'(dut.r_count), 32'd0);
    tick();

    // Async reset with three entries queued
    chk_regA = 5'd20;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_rd = 5'(20 + i); md_data = 32'h20 + 32'(i);
      alu_valid = 1'b1; alu_rd = 5'(25 + i); alu_data = 32'h25 + 32'(i);
      expect_wr(5'(25 + i), 32'h25 + 32'(i));
      tick();
    end
    check("pre_rst_count", 32'(dut.r_count), 32'd3);
    check("pre_rst_pendA", 32'(chk_pendingA), 32'd1);
    @(negedge clock);
    #1;
    md_valid = 1'b0; alu_valid = 1'b0;
    ctrl_reset = 1'b1;
    #1;
    check("async_we", 32'(ctrl_writeEnable), 32'd0);
    check("async_reg", 32'(ctrl_writeReg), 32'd0);
    check("async_data", data_writeReg, 32'd0);
    check("async_count", 32'(dut.r_count), 32'd0);
    check("async_pendA", 32'(chk_pendingA), 32'd0);
    check("async_md_ready", 32'(md_ready), 32'd1);
    check("async_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    tick();
    ctrl_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_we", 32'(ctrl_writeEnable), 32'd0);
    end
    check("post_rst_count", 32'(dut.r_count), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
